// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray encoder-decoder family.
package gray_pkg;

  // Widest code any Gray block in this family is built for.
  localparam int GRAY_MAX_WIDTH = 16;

  // Reference binary-to-Gray conversion, usable by RTL and benches alike.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] value
  );
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational binary-to-Gray encoder: the mirror image of the Gray decoder.
// Each Gray bit is the xor of a binary bit and its upper neighbour, and the
// MSB passes straight through.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // One xor gate per lower bit, pairing each bit with the bit above it.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_xor
    assign gray_o[i] = bin_i[i] ^ bin_i[i+1];
  end

  assign gray_o[WIDTH-1] = bin_i[WIDTH-1];

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output and a roll-over
// pulse. The Gray value is encoded from the next binary value and captured
// on the same edge as the binary count, so gray is always glitch-free and
// consistent with bin.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_q;
  logic             wrap_d;

  // Next binary value and roll-over flag: load beats count, count beats hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = (bin_q == '0);
      end
    end
  end

  // Gray code is encoded from the next binary value, never from the flops.
  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  // Binary count, Gray code and wrap pulse all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4) using an expected-value
// scoreboard fed by a small behavioural model of the counter.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] binVal;
    logic [WIDTH-1:0] grayVal;
    logic             wrapVal;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             up_dn = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_bin = '0;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  expect_t          scoreboard[$];
  logic [WIDTH-1:0] modelBin = '0;
  int               checkCount = 0;
  int               errorCount = 0;

  // Expected Gray sequence for sixteen up-steps starting from zero.
  logic [WIDTH-1:0] grayUpSeq [16] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
  };

  gray_counter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_bin(load_bin),
    .bin     (bin),
    .gray    (gray),
    .wrap    (wrap)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] modelGray(input logic [WIDTH-1:0] b);
    logic [GRAY_MAX_WIDTH-1:0] g;
    g = bin2gray(GRAY_MAX_WIDTH'(b));
    return g[WIDTH-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic applyStimulus(input logic enIn, input logic upIn, input logic loadIn,
                               input logic [WIDTH-1:0] loadVal);
    expect_t          exp;
    expect_t          got;
    logic [WIDTH-1:0] prevGray;
    logic             countStep;
    @(negedge clk);
    en       = enIn;
    up_dn    = upIn;
    load     = loadIn;
    load_bin = loadVal;
    exp.wrapVal = 1'b0;
    if (loadIn) begin
      modelBin = loadVal;
    end else if (enIn) begin
      if (upIn) begin
        exp.wrapVal = (modelBin == {WIDTH{1'b1}});
        modelBin    = modelBin + 4'd1;
      end else begin
        exp.wrapVal = (modelBin == '0);
        modelBin    = modelBin - 4'd1;
      end
    end
    exp.binVal  = modelBin;
    exp.grayVal = modelGray(modelBin);
    scoreboard.push_back(exp);
    prevGray  = gray;
    countStep = enIn && !loadIn;
    @(posedge clk);
    #1;
    got = scoreboard.pop_front();
    checkOutput("bin", 32'(bin), 32'(got.binVal));
    checkOutput("gray", 32'(gray), 32'(got.grayVal));
    checkOutput("wrap", 32'(wrap), 32'(got.wrapVal));
    if (countStep) checkOutput("oneBitChange", 32'($countones(prevGray ^ gray)), 32'd1);
  endtask

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetBin", 32'(bin), 32'd0);
    checkOutput("resetGray", 32'(gray), 32'd0);
    checkOutput("resetWrap", 32'(wrap), 32'd0);
    rst_n    = 1'b1;
    modelBin = '0;

    // Sixteen up-steps from zero, including the roll-over.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("upSeqGray", 32'(gray), 32'(grayUpSeq[i]));
      checkOutput("upSeqWrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    // Asynchronous reset mid-cycle with counting still enabled.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBin", 32'(bin), 32'd0);
    checkOutput("asyncRstGray", 32'(gray), 32'd0);
    checkOutput("asyncRstWrap", 32'(wrap), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    modelBin = '0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);

    // Count down from zero: wraps to all ones, then steps down once more.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("downFirstBin", 32'(bin), 32'hF);
    checkOutput("downFirstGray", 32'(gray), 32'h8);
    checkOutput("downFirstWrap", 32'(wrap), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("downSecondGray", 32'(gray), 32'h9);
    checkOutput("downSecondWrap", 32'(wrap), 32'd0);

    // Load, then load colliding with an enabled up-count.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd10);
    checkOutput("loadTenGray", 32'(gray), 32'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd5);
    checkOutput("loadWinsBin", 32'(bin), 32'h5);
    checkOutput("loadWinsGray", 32'(gray), 32'h7);

    // Direction reversal every cycle around 0111/1000.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd7);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i % 2) == 0, 1'b0, '0);
      checkOutput("reverseGray", 32'(gray), ((i % 2) == 0) ? 32'hC : 32'h4);
    end

    // Hold for five cycles at 0011.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("holdGray", 32'(gray), 32'h2);
    end

    checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
